// File: rtl/tpu_dma_pkg.sv
// Shared types and constants for the TPU DMA loader (FSM state codes, beat size and width).
package tpu_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] DMA_SIZE_64 = 3'b011;
  localparam int         BEAT_W      = 64;

endpackage

// File: rtl/tpu_dma_loader.sv
// Streams a configured range of 64-bit words from DMA into the TPU scratchpad in bursts.
// Optional status counter on 'debug' is enabled by defining TPU_DMA_LOADER_DEBUG_EN.
module tpu_dma_loader
  import tpu_dma_pkg::*;
#(
  parameter int SPM_AW    = 12,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_done,
  input  logic [31:0]       conf_info_reg0,
  input  logic [31:0]       conf_info_reg1,
  input  logic [31:0]       conf_info_reg2,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  output logic [4:0]        dma_read_ctrl_data_user,
  input  logic              dma_read_chnl_valid,
  output logic              dma_read_chnl_ready,
  input  logic [BEAT_W-1:0] dma_read_chnl_data,
  output logic              spm_we,
  output logic [SPM_AW-1:0] spm_addr,
  output logic [BEAT_W-1:0] spm_wdata,
  output logic              load_done,
  output logic [31:0]       debug
);

  localparam logic [31:0] BURST_MAX = 32'(MAX_BURST);

  state_e            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       issued_q, issued_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [31:0]       beats_q, beats_d;
  logic [SPM_AW-1:0] dest_q, dest_d;
  logic [SPM_AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [SPM_AW-1:0] spm_addr_q, spm_addr_d;
  logic [BEAT_W-1:0] spm_wdata_q, spm_wdata_d;
  logic              spm_we_q, spm_we_d;
  logic              load_done_q, load_done_d;
  logic [31:0]       burst_len;
  logic              unused_cfg_bits;

  assign unused_cfg_bits = ^conf_info_reg2[31:SPM_AW];
  assign burst_len = (remaining_q > BURST_MAX) ? BURST_MAX : remaining_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issued_q    <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      dest_q      <= '0;
      wr_cnt_q    <= '0;
      spm_addr_q  <= '0;
      spm_wdata_q <= '0;
      spm_we_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issued_q    <= issued_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      dest_q      <= dest_d;
      wr_cnt_q    <= wr_cnt_d;
      spm_addr_q  <= spm_addr_d;
      spm_wdata_q <= spm_wdata_d;
      spm_we_q    <= spm_we_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    state_d                   = state_q;
    base_d                    = base_q;
    issued_d                  = issued_q;
    remaining_d               = remaining_q;
    beats_d                   = beats_q;
    dest_d                    = dest_q;
    wr_cnt_d                  = wr_cnt_q;
    spm_addr_d                = spm_addr_q;
    spm_wdata_d               = spm_wdata_q;
    spm_we_d                  = 1'b0;
    load_done_d               = 1'b0;
    dma_read_ctrl_valid       = 1'b0;
    dma_read_ctrl_data_index  = '0;
    dma_read_ctrl_data_length = '0;
    dma_read_chnl_ready       = 1'b0;

    case (state_q)
      IDLE: begin
        if (conf_done) begin
          base_d      = conf_info_reg0;
          remaining_d = conf_info_reg1;
          issued_d    = '0;
          dest_d      = conf_info_reg2[SPM_AW-1:0];
          wr_cnt_d    = '0;
          state_d     = (conf_info_reg1 != 32'd0) ? REQ : DONE;
        end
      end
      // Request fields come purely from registers, so they stay put while ready is low.
      REQ: begin
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = base_q + issued_q;
        dma_read_ctrl_data_length = burst_len;
        if (dma_read_ctrl_ready) begin
          issued_d    = issued_q + burst_len;
          remaining_d = remaining_q - burst_len;
          beats_d     = burst_len;
          state_d     = DATA;
        end
      end
      DATA: begin
        dma_read_chnl_ready = 1'b1;
        if (dma_read_chnl_valid) begin
          spm_we_d    = 1'b1;
          spm_addr_d  = dest_q + wr_cnt_q;
          spm_wdata_d = dma_read_chnl_data;
          wr_cnt_d    = wr_cnt_q + SPM_AW'(1);
          beats_d     = beats_q - 32'd1;
          if (beats_q == 32'd1) begin
            state_d = (remaining_q != 32'd0) ? REQ : DONE;
          end
        end
      end
      // The pulse is registered so it lands after the final scratchpad write.
      DONE: begin
        load_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_read_ctrl_data_size = DMA_SIZE_64;
  assign dma_read_ctrl_data_user = '0;
  assign spm_we                  = spm_we_q;
  assign spm_addr                = spm_addr_q;
  assign spm_wdata               = spm_wdata_q;
  assign load_done               = load_done_q;

`ifdef TPU_DMA_LOADER_DEBUG_EN
  logic [23:0] dbg_beats_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_beats_q <= '0;
    end else if ((state_q == IDLE) && conf_done) begin
      dbg_beats_q <= '0;
    end else if ((state_q == DATA) && dma_read_chnl_valid) begin
      dbg_beats_q <= dbg_beats_q + 24'd1;
    end
  end

  assign debug = {6'd0, state_q, dbg_beats_q};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_tpu_dma_loader.sv
// Self-checking bench for tpu_dma_loader: vector table, hand-written corner sequences and
// randomized transfers compared against a burst/address model of the loader.
module tb_tpu_dma_loader;
  import tpu_dma_pkg::*;

  localparam int SPM_AW    = 12;
  localparam int MAX_BURST = 16;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] len;
  } req_t;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] len;
    logic [31:0] dest;
    bit          rndValid;
    int          expReqs;
    logic [31:0] expLastLen;
    logic [11:0] expFirstAddr;
    logic [11:0] expLastAddr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        conf_done;
  logic [31:0] conf_info_reg0;
  logic [31:0] conf_info_reg1;
  logic [31:0] conf_info_reg2;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic [4:0]  dma_read_ctrl_data_user;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;
  logic        spm_we;
  logic [11:0] spm_addr;
  logic [63:0] spm_wdata;
  logic        load_done;
  logic [31:0] debug;

  int          errors = 0;
  int          checks = 0;
  int          doneCount = 0;
  int          beatCount = 0;
  req_t        reqQ[$];
  wr_t         wrQ[$];
  logic [31:0] pendQ[$];
  bit          rndValid = 0;
  bit          rndReady = 0;
  logic        mainReady = 1'b1;
  logic        prevStall = 1'b0;
  logic [31:0] prevIdx = '0;
  logic [31:0] prevLen = '0;

  tpu_dma_loader #(.SPM_AW(SPM_AW), .MAX_BURST(MAX_BURST)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .conf_done                (conf_done),
    .conf_info_reg0           (conf_info_reg0),
    .conf_info_reg1           (conf_info_reg1),
    .conf_info_reg2           (conf_info_reg2),
    .dma_read_ctrl_valid      (dma_read_ctrl_valid),
    .dma_read_ctrl_ready      (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size  (dma_read_ctrl_data_size),
    .dma_read_ctrl_data_user  (dma_read_ctrl_data_user),
    .dma_read_chnl_valid      (dma_read_chnl_valid),
    .dma_read_chnl_ready      (dma_read_chnl_ready),
    .dma_read_chnl_data       (dma_read_chnl_data),
    .spm_we                   (spm_we),
    .spm_addr                 (spm_addr),
    .spm_wdata                (spm_wdata),
    .load_done                (load_done),
    .debug                    (debug)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents are a function of the word index so misplaced or repeated beats show up.
  function automatic logic [63:0] memWord(input logic [31:0] idx);
    return {idx ^ 32'hDEAD_BEEF, ~idx};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctrlValid"}, 64'(dma_read_ctrl_valid), 64'd0);
    checkOutput({tag, "_ctrlIndex"}, 64'(dma_read_ctrl_data_index), 64'd0);
    checkOutput({tag, "_ctrlLength"}, 64'(dma_read_ctrl_data_length), 64'd0);
    checkOutput({tag, "_ctrlSize"}, 64'(dma_read_ctrl_data_size), 64'd3);
    checkOutput({tag, "_ctrlUser"}, 64'(dma_read_ctrl_data_user), 64'd0);
    checkOutput({tag, "_chnlReady"}, 64'(dma_read_chnl_ready), 64'd0);
    checkOutput({tag, "_spmWe"}, 64'(spm_we), 64'd0);
    checkOutput({tag, "_spmAddr"}, 64'(spm_addr), 64'd0);
    checkOutput({tag, "_spmWdata"}, spm_wdata, 64'd0);
    checkOutput({tag, "_loadDone"}, 64'(load_done), 64'd0);
    checkOutput({tag, "_debug"}, 64'(debug), 64'd0);
  endtask

  // Negedge monitor: records handshakes, writes and completions; checks request stability.
  always @(negedge clk) begin
    if (dma_read_ctrl_valid && prevStall) begin
      checkOutput("reqIndexStable", 64'(dma_read_ctrl_data_index), 64'(prevIdx));
      checkOutput("reqLengthStable", 64'(dma_read_ctrl_data_length), 64'(prevLen));
    end
    prevStall = dma_read_ctrl_valid && !dma_read_ctrl_ready;
    prevIdx   = dma_read_ctrl_data_index;
    prevLen   = dma_read_ctrl_data_length;
    if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
      reqQ.push_back('{dma_read_ctrl_data_index, dma_read_ctrl_data_length});
      checkOutput("reqSize", 64'(dma_read_ctrl_data_size), 64'(DMA_SIZE_64));
      checkOutput("reqUser", 64'(dma_read_ctrl_data_user), 64'd0);
      for (int k = 0; k < int'(dma_read_ctrl_data_length) && k < 4096; k++)
        pendQ.push_back(dma_read_ctrl_data_index + 32'(k));
    end
    if (dma_read_chnl_valid && dma_read_chnl_ready) begin
      if (pendQ.size() > 0) void'(pendQ.pop_front());
      beatCount++;
    end
    if (spm_we) wrQ.push_back('{spm_addr, spm_wdata});
    if (load_done) doneCount++;
  end

  // DMA responder: returns pending words in order, optionally with random gaps and ready.
  initial begin
    dma_read_chnl_valid = 1'b0;
    dma_read_chnl_data  = '0;
    dma_read_ctrl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        pendQ.delete();
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = '0;
      end else if (pendQ.size() > 0 && (!rndValid || $urandom_range(0, 1) == 1)) begin
        dma_read_chnl_valid = 1'b1;
        dma_read_chnl_data  = memWord(pendQ[0]);
      end else begin
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = '0;
      end
      dma_read_ctrl_ready = rndReady ? ($urandom_range(0, 1) == 1) : mainReady;
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the start pulse was sampled.
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] len,
                               input logic [31:0] dest);
    reqQ.delete();
    wrQ.delete();
    doneCount      = 0;
    beatCount      = 0;
    conf_info_reg0 = base;
    conf_info_reg1 = len;
    conf_info_reg2 = dest;
    conf_done      = 1'b1;
    @(posedge clk);
    #1;
    conf_done      = 1'b0;
    conf_info_reg0 = $urandom;
    conf_info_reg1 = $urandom;
    conf_info_reg2 = $urandom;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (doneCount == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitDone: no load_done after %0d cycles, expected 1", budget);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference: split the range into MAX_BURST chunks, one scratchpad write per word.
  task automatic checkModel(input logic [31:0] base, input logic [31:0] len,
                            input logic [31:0] dest);
    req_t expR[$];
    wr_t  expW[$];
    longint off = 0;
    longint chunk;
    while (off < longint'(len)) begin
      chunk = longint'(len) - off;
      if (chunk > MAX_BURST) chunk = MAX_BURST;
      expR.push_back('{base + 32'(off), 32'(chunk)});
      off += chunk;
    end
    for (longint k = 0; k < longint'(len); k++)
      expW.push_back('{12'((longint'(dest) + k) % 4096), memWord(base + 32'(k))});
    checkOutput("modelReqCount", 64'(reqQ.size()), 64'(expR.size()));
    for (int i = 0; i < reqQ.size() && i < expR.size(); i++) begin
      checkOutput("modelReqIndex", 64'(reqQ[i].idx), 64'(expR[i].idx));
      checkOutput("modelReqLength", 64'(reqQ[i].len), 64'(expR[i].len));
    end
    checkOutput("modelWriteCount", 64'(wrQ.size()), 64'(expW.size()));
    for (int i = 0; i < wrQ.size() && i < expW.size(); i++) begin
      checkOutput("modelWriteAddr", 64'(wrQ[i].addr), 64'(expW[i].addr));
      checkOutput("modelWriteData", wrQ[i].data, expW[i].data);
    end
    checkOutput("modelLoadDoneCount", 64'(doneCount), 64'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_0100, 32'd4,  32'h0000_0000, 1'b0, 1, 32'd4,  12'h000, 12'h003};
    vecs[1] = '{32'h0000_2000, 32'd40, 32'h0000_0010, 1'b0, 3, 32'd8,  12'h010, 12'h037};
    vecs[2] = '{32'h0000_0055, 32'd0,  32'h0000_0000, 1'b0, 0, 32'd0,  12'h000, 12'h000};
    vecs[3] = '{32'h0000_0300, 32'd4,  32'hABC0_0FFE, 1'b1, 1, 32'd4,  12'hFFE, 12'h001};
    vecs[4] = '{32'hFFFF_FFF8, 32'd20, 32'h0000_0007, 1'b1, 2, 32'd4,  12'h007, 12'h01A};
    vecs[5] = '{32'h0000_0040, 32'd16, 32'h0000_0100, 1'b0, 1, 32'd16, 12'h100, 12'h10F};
    vecs[6] = '{32'h0000_1234, 32'd17, 32'h0000_0FF0, 1'b1, 2, 32'd1,  12'hFF0, 12'h000};

    rst            = 1'b0;
    conf_done      = 1'b0;
    conf_info_reg0 = '0;
    conf_info_reg1 = '0;
    conf_info_reg2 = '0;
    #3;
    checkIdleOutputs("inReset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("afterReset");

    for (int i = 0; i < 7; i++) begin
      rndValid = vecs[i].rndValid;
      applyStimulus(vecs[i].base, vecs[i].len, vecs[i].dest);
      waitDone(400);
      checkOutput("vecReqCount", 64'(reqQ.size()), 64'(vecs[i].expReqs));
      if (vecs[i].expReqs > 0 && reqQ.size() > 0)
        checkOutput("vecLastReqLength", 64'(reqQ[$].len), 64'(vecs[i].expLastLen));
      if (vecs[i].len != 0) begin
        if (wrQ.size() == 0) begin
          checkOutput("vecWriteCount", 64'd0, 64'(vecs[i].len));
        end else begin
          checkOutput("vecFirstAddr", 64'(wrQ[0].addr), 64'(vecs[i].expFirstAddr));
          checkOutput("vecLastAddr", 64'(wrQ[$].addr), 64'(vecs[i].expLastAddr));
        end
      end
      checkModel(vecs[i].base, vecs[i].len, vecs[i].dest);
    end

    // Zero-length job: no request, completion two cycles after the start pulse.
    rndValid = 0;
    applyStimulus(32'h0000_0077, 32'd0, 32'h0000_0003);
    checkOutput("len0ValidN1", 64'(dma_read_ctrl_valid), 64'd0);
    checkOutput("len0DoneN1", 64'(load_done), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("len0DoneN2", 64'(load_done), 64'd1);
    checkOutput("len0ValidN2", 64'(dma_read_ctrl_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("len0DoneN3", 64'(load_done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("len0ReqCount", 64'(reqQ.size()), 64'd0);
    checkOutput("len0DoneCount", 64'(doneCount), 64'd1);

    // Stalled request with a stray start pulse that must be ignored.
    mainReady = 1'b0;
    rndValid  = 1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(32'h0000_7000, 32'd20, 32'h0000_0020);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stallValid", 64'(dma_read_ctrl_valid), 64'd1);
      checkOutput("stallIndex", 64'(dma_read_ctrl_data_index), 64'h7000);
      checkOutput("stallLength", 64'(dma_read_ctrl_data_length), 64'd16);
      if (c == 2) begin
        conf_done      = 1'b1;
        conf_info_reg0 = 32'h0000_9999;
        conf_info_reg1 = 32'd3;
        conf_info_reg2 = 32'h0000_0005;
      end else begin
        conf_done = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    conf_done = 1'b0;
    mainReady = 1'b1;
    waitDone(400);
    checkModel(32'h0000_7000, 32'd20, 32'h0000_0020);

    // Randomized jobs with random valid/ready on both DMA channels.
    rndValid = 1;
    rndReady = 1;
    for (int r = 0; r < 6; r++) begin
      logic [31:0] b, l, d;
      b = $urandom;
      l = 32'($urandom_range(0, 50));
      d = $urandom;
      applyStimulus(b, l, d);
      waitDone(int'(l) * 12 + 60);
      checkModel(b, l, d);
    end
    rndReady = 0;
    rndValid = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after three of eight beats, then a clean restart.
    applyStimulus(32'h0000_0A00, 32'd8, 32'h0000_0040);
    begin
      int n = 0;
      while (beatCount < 3 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("midResetBeatsSeen", 64'(beatCount >= 3), 64'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    checkIdleOutputs("midReset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midResetNoLoadDone", 64'(doneCount), 64'd0);
    checkIdleOutputs("midResetRelease");
    applyStimulus(32'h0000_0B00, 32'd8, 32'h0000_0040);
    waitDone(200);
    checkModel(32'h0000_0B00, 32'd8, 32'h0000_0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_dma_loader.md
TPU_DMA_LOADER -- requirements
Module: tpu_dma_loader

Interface
REQ-001 SHALL have parameter SPM_AW, default 12, scratchpad word-address width.
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum 64-bit beats per DMA read request (power of two, 1..256).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 conf_done  in  1  start pulse; config registers valid while high.
REQ-006 conf_info_reg0  in  32  source base index, in 64-bit words.
REQ-007 conf_info_reg1  in  32  total transfer length, in 64-bit words.
REQ-008 conf_info_reg2  in  32  scratchpad destination base; low SPM_AW bits used.
REQ-009 dma_read_ctrl_valid / _ready  out / in  1 / 1  read-request handshake.
REQ-010 dma_read_ctrl_data_index / _length  out  32 / 32  request word index / beat count.
REQ-011 dma_read_ctrl_data_size / _user  out  3 / 5  beat size / user tag.
REQ-012 dma_read_chnl_valid / _ready / _data  in / out / in  1 / 1 / 64  read data beats.
REQ-013 spm_we / spm_addr / spm_wdata  out  1 / SPM_AW / 64  scratchpad write port.
REQ-014 load_done  out  1  one-cycle completion pulse to the TPU compute stage.
REQ-015 debug  out  32  status word.

Function
REQ-016 FSM states SHALL be IDLE, REQ, DATA, DONE.
REQ-017 IDLE: on conf_done, SHALL latch reg0/reg1/reg2; go REQ if length>0, else DONE.
REQ-018 REQ: dma_read_ctrl_valid=1; index=base+issued; length=min(remaining, MAX_BURST); size=3'b011; user=0; all held stable until ready.
REQ-019 REQ->DATA on the cycle valid&&ready, with beat counter loaded to that request length.
REQ-020 dma_read_chnl_ready SHALL be 1 only in DATA; a beat is accepted on valid&&ready.
REQ-021 Each accepted beat SHALL produce spm_we=1 the next cycle, spm_wdata=beat, spm_addr=dest+beats accepted so far; SPM address wraps modulo 2^SPM_AW.
REQ-022 After the last beat of a burst: go REQ if remaining>0, else DONE.
REQ-023 DONE: load_done=1 for exactly one cycle, then IDLE.
REQ-024 conf_done while not IDLE SHALL be ignored.
REQ-025 Latency: conf_done at cycle N -> dma_read_ctrl_valid at N+1.
REQ-026 Remaining/issued counters SHALL be 32 bits; base+issued wraps modulo 2^32.

Reset
REQ-027 rst low SHALL asynchronously force IDLE and clear all counters and latched config.
REQ-028 During and after reset until first conf_done: all valid/ready/we/load_done = 0, index/length/addr/wdata = 0, size = 3'b011, user = 0, debug = 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer; no load_done is emitted.

Configuration
REQ-030 Macro TPU_DMA_LOADER_DEBUG_EN defined: debug[31:24] = FSM state code (IDLE=0, REQ=1, DATA=2, DONE=3); debug[23:0] = beats accepted since last conf_done.
REQ-031 Macro TPU_DMA_LOADER_DEBUG_EN undefined: debug tied to 0; no counter logic.

Structure
REQ-032 Shared package tpu_dma_pkg SHALL hold the FSM state enum, DMA_SIZE_64 = 3'b011, and the 64-bit beat width.
REQ-033 Single module; no sub-module.

Verification
REQ-034 base=0x100, len=4, dest=0, MAX_BURST=16, ready always 1 -> one request (index 0x100, length 4); 4 spm writes to addr 0..3 with matching data; one load_done.
REQ-035 len=40, MAX_BURST=16 -> three requests: index base+0/16/32, lengths 16/16/8; 40 writes; one load_done.
REQ-036 len=0 -> no dma_read_ctrl_valid; load_done exactly two cycles after conf_done.
REQ-037 dma_read_ctrl_ready held low 5 cycles; chnl_valid toggled randomly -> request fields stable throughout; no beat lost or duplicated.
REQ-038 dest=0xFFE, SPM_AW=12, len=4 -> spm_addr 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 rst asserted after 3 of 8 beats -> outputs zero immediately; no load_done; new conf_done restarts cleanly.
